// File: rtl/router_pkg.sv
// Router-wide default sizing shared by the VC arbiters and the output-VC trackers.
package router_pkg;
  localparam int no_inport                   = 6;
  localparam int floorplusone_log2_no_inport = 3;
  localparam int no_vc                       = 13;
  localparam int floorplusone_log2_no_vc     = 4;
  localparam int buf_depth                   = 4;

  localparam int vc_idx_w = floorplusone_log2_no_vc;
  typedef logic [vc_idx_w-1:0] vc_idx_t;
endpackage

// File: rtl/out_vc_tracker_if.sv
// Bundle between the update/release arbiter, switch/credit logic and one output-port VC tracker.
interface out_vc_tracker_if #(
  parameter int no_inport               = router_pkg::no_inport,
  parameter int no_vc                   = router_pkg::no_vc,
  parameter int floorplusone_log2_no_vc = router_pkg::floorplusone_log2_no_vc
);
  logic                               update_en;
  logic [floorplusone_log2_no_vc-1:0] vc_no;
  logic [no_vc-1:0]                   allowed_vcs;
  logic [no_inport-1:0]               port_no_vec;
  logic                               release_en;
  logic [floorplusone_log2_no_vc-1:0] release_vc;
  logic                               flit_sent_en;
  logic [floorplusone_log2_no_vc-1:0] flit_sent_vc;
  logic [no_vc-1:0]                   credit_in;

  logic [no_vc-1:0]                   tags;
  logic                               grant_valid;
  logic [floorplusone_log2_no_vc-1:0] grant_outvc;
  logic [floorplusone_log2_no_vc-1:0] grant_invc;
  logic [no_inport-1:0]               grant_port_vec;
  logic [no_vc-1:0]                   credit_avail;
  logic                               err;

  modport master (
    output update_en, vc_no, allowed_vcs, port_no_vec,
           release_en, release_vc, flit_sent_en, flit_sent_vc, credit_in,
    input  tags, grant_valid, grant_outvc, grant_invc, grant_port_vec,
           credit_avail, err
  );

  modport slave (
    input  update_en, vc_no, allowed_vcs, port_no_vec,
           release_en, release_vc, flit_sent_en, flit_sent_vc, credit_in,
    output tags, grant_valid, grant_outvc, grant_invc, grant_port_vec,
           credit_avail, err
  );
endinterface

// File: rtl/vc_credit_counter.sv
// Saturating downstream-credit counter for one output VC; flags credit-protocol violations.
module vc_credit_counter import router_pkg::*; #(
  parameter int cnt_w = floorplusone_log2_no_inport,
  parameter int depth = buf_depth
) (
  input  logic clk,
  input  logic rs,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic err
);
  logic [cnt_w-1:0] count_q;
  logic [cnt_w-1:0] count_d;
  logic             nonzero_q;

  // A simultaneous send and return cancel out, so neither saturation check applies.
  always_comb begin
    count_d = count_q;
    err     = 1'b0;
    if (inc && !dec) begin
      if (count_q == cnt_w'(depth)) err = 1'b1;
      else                          count_d = count_q + cnt_w'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) err = 1'b1;
      else               count_d = count_q - cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      count_q   <= cnt_w'(depth);
      nonzero_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      nonzero_q <= (count_d != '0);
    end
  end

  assign nonzero = nonzero_q;
endmodule

// File: rtl/out_vc_tracker.sv
// Output-port VC tracker: busy tags, lowest-free-VC binding, tail release and per-VC credits.
module out_vc_tracker #(
  parameter int no_inport                   = router_pkg::no_inport,
  parameter int floorplusone_log2_no_inport = router_pkg::floorplusone_log2_no_inport,
  parameter int no_vc                       = router_pkg::no_vc,
  parameter int floorplusone_log2_no_vc     = router_pkg::floorplusone_log2_no_vc,
  parameter int buf_depth                   = router_pkg::buf_depth
) (
  input  logic           clk,
  input  logic           rs,
  out_vc_tracker_if.slave bus
);
  logic [no_vc-1:0]                   tags_q;
  logic [no_vc-1:0]                   tags_d;
  logic [no_vc-1:0]                   cand;
  logic [no_vc-1:0]                   grant_mask;
  logic [no_vc-1:0]                   release_mask;
  logic [no_vc-1:0]                   cnt_err;
  logic [no_vc-1:0]                   cnt_nz;
  logic [floorplusone_log2_no_vc-1:0] pick;
  logic [floorplusone_log2_no_vc-1:0] grant_outvc_q;
  logic [floorplusone_log2_no_vc-1:0] grant_invc_q;
  logic [no_inport-1:0]               grant_port_q;
  logic                               cand_any;
  logic                               do_grant;
  logic                               port_bad;
  logic                               release_in_range;
  logic                               proto_err;
  logic                               grant_valid_q;
  logic                               err_q;

  // Lowest-index free allowed VC; scanning downward lets the lowest set bit win.
  always_comb begin
    cand     = bus.allowed_vcs & ~tags_q;
    cand_any = |cand;
    pick     = '0;
    for (int i = no_vc - 1; i >= 0; i--) begin
      if (cand[i]) pick = floorplusone_log2_no_vc'(i);
    end
  end

  // Allocation reads pre-edge tags, so a VC being released this cycle is never picked.
  always_comb begin
    do_grant         = bus.update_en && cand_any;
    grant_mask       = do_grant ? (no_vc'(1) << pick) : '0;
    release_in_range = int'(bus.release_vc) < no_vc;
    release_mask     = (bus.release_en && release_in_range) ? (no_vc'(1) << bus.release_vc) : '0;
    port_bad         = (bus.port_no_vec == '0) ||
                       ((bus.port_no_vec & (bus.port_no_vec - no_inport'(1))) != '0);
    proto_err        = (bus.update_en && (!cand_any || port_bad)) ||
                       (bus.release_en && (!release_in_range || ((tags_q & release_mask) == '0))) ||
                       (|cnt_err);
    tags_d           = (tags_q & ~release_mask) | grant_mask;
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      tags_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_outvc_q <= '0;
      grant_invc_q  <= '0;
      grant_port_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      tags_q        <= tags_d;
      grant_valid_q <= do_grant;
      err_q         <= err_q | proto_err;
      if (do_grant) begin
        grant_outvc_q <= pick;
        grant_invc_q  <= bus.vc_no;
        grant_port_q  <= bus.port_no_vec;
      end
    end
  end

  for (genvar g = 0; g < no_vc; g++) begin : g_credit
    vc_credit_counter #(
      .cnt_w (floorplusone_log2_no_inport),
      .depth (buf_depth)
    ) u_cnt (
      .clk     (clk),
      .rs      (rs),
      .inc     (bus.credit_in[g]),
      .dec     (bus.flit_sent_en && (int'(bus.flit_sent_vc) == g)),
      .nonzero (cnt_nz[g]),
      .err     (cnt_err[g])
    );
  end

  assign bus.tags           = tags_q;
  assign bus.grant_valid    = grant_valid_q;
  assign bus.grant_outvc    = grant_outvc_q;
  assign bus.grant_invc     = grant_invc_q;
  assign bus.grant_port_vec = grant_port_q;
  assign bus.credit_avail   = cnt_nz;
  assign bus.err            = err_q;
endmodule

// File: tb/tb_out_vc_tracker.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs, a monitor pops and compares.
module tb_out_vc_tracker;
  import router_pkg::*;

  typedef struct {
    bit                  rs;
    bit                  upd;
    bit [vc_idx_w-1:0]   vcn;
    bit [no_vc-1:0]      allowed;
    bit [no_inport-1:0]  port;
    bit                  rel;
    bit [vc_idx_w-1:0]   rvc;
    bit                  sent;
    bit [vc_idx_w-1:0]   svc;
    bit [no_vc-1:0]      cin;
  } stim_t;

  typedef struct {
    bit [no_vc-1:0]      tags;
    bit [no_vc-1:0]      avail;
    bit                  err;
    bit                  gv;
    bit [vc_idx_w-1:0]   goutvc;
    bit [vc_idx_w-1:0]   ginvc;
    bit [no_inport-1:0]  gport;
  } exp_t;

  logic clk = 1'b0;
  logic rs;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model state: plain arrays and integer credit counts.
  bit                 m_busy[no_vc];
  int                 m_cred[no_vc];
  bit                 m_err;
  bit [vc_idx_w-1:0]  m_outvc;
  bit [vc_idx_w-1:0]  m_invc;
  bit [no_inport-1:0] m_port;

  out_vc_tracker_if bus ();

  out_vc_tracker dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rs = 0; s.upd = 0; s.vcn = '0; s.allowed = '0; s.port = '0;
    s.rel = 0; s.rvc = '0; s.sent = 0; s.svc = '0; s.cin = '0;
    return s;
  endfunction

  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    int   pick;
    pick = -1;
    if (s.rs) begin
      for (int v = 0; v < no_vc; v++) begin
        m_busy[v] = 0;
        m_cred[v] = buf_depth;
      end
      m_err = 0; m_outvc = '0; m_invc = '0; m_port = '0;
    end else begin
      if (s.upd) begin
        for (int v = 0; v < no_vc; v++)
          if (pick < 0 && s.allowed[v] && !m_busy[v]) pick = v;
        if (pick < 0) m_err = 1;
        if ($countones(s.port) != 1) m_err = 1;
      end
      if (s.rel) begin
        if (int'(s.rvc) >= no_vc) m_err = 1;
        else begin
          if (!m_busy[s.rvc]) m_err = 1;
          m_busy[s.rvc] = 0;
        end
      end
      if (pick >= 0) begin
        m_busy[pick] = 1;
        m_outvc = vc_idx_w'(pick);
        m_invc  = s.vcn;
        m_port  = s.port;
      end
      for (int v = 0; v < no_vc; v++) begin
        bit d;
        bit i;
        d = s.sent && (int'(s.svc) == v);
        i = s.cin[v];
        if (d && !i) begin
          if (m_cred[v] == 0) m_err = 1;
          else m_cred[v] = m_cred[v] - 1;
        end else if (i && !d) begin
          if (m_cred[v] == buf_depth) m_err = 1;
          else m_cred[v] = m_cred[v] + 1;
        end
      end
    end
    for (int v = 0; v < no_vc; v++) begin
      e.tags[v]  = m_busy[v];
      e.avail[v] = (m_cred[v] != 0);
    end
    e.err    = m_err;
    e.gv     = (pick >= 0);
    e.goutvc = m_outvc;
    e.ginvc  = m_invc;
    e.gport  = m_port;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rs               = s.rs;
    bus.update_en    = s.upd;
    bus.vc_no        = s.vcn;
    bus.allowed_vcs  = s.allowed;
    bus.port_no_vec  = s.port;
    bus.release_en   = s.rel;
    bus.release_vc   = s.rvc;
    bus.flit_sent_en = s.sent;
    bus.flit_sent_vc = s.svc;
    bus.credit_in    = s.cin;
    exp_q.push_back(model_step(s));
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    int    busy_list[$];
    s = idle_stim();
    s.rs      = ($urandom_range(99) < 3);
    s.upd     = $urandom_range(1);
    s.vcn     = vc_idx_w'($urandom_range(no_vc - 1));
    s.allowed = no_vc'($urandom);
    if ($urandom_range(3) == 0) s.allowed = no_vc'(1) << $urandom_range(no_vc - 1);
    if ($urandom_range(9) == 0) s.port = no_inport'($urandom);
    else                        s.port = no_inport'(1) << $urandom_range(no_inport - 1);
    s.rel = ($urandom_range(2) == 0);
    for (int v = 0; v < no_vc; v++) if (m_busy[v]) busy_list.push_back(v);
    if (busy_list.size() > 0 && $urandom_range(3) != 0)
      s.rvc = vc_idx_w'(busy_list[$urandom_range(busy_list.size() - 1)]);
    else
      s.rvc = vc_idx_w'($urandom_range(15));
    s.sent = $urandom_range(1);
    s.svc  = vc_idx_w'($urandom_range(no_vc - 1));
    for (int v = 0; v < no_vc; v++) s.cin[v] = ($urandom_range(5) == 0);
    return s;
  endfunction

  // Monitor: the DUT presents a full output set every cycle, compared just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("tags",           32'(bus.tags),           32'(e.tags));
        checkOutput("credit_avail",   32'(bus.credit_avail),   32'(e.avail));
        checkOutput("err",            32'(bus.err),            32'(e.err));
        checkOutput("grant_valid",    32'(bus.grant_valid),    32'(e.gv));
        checkOutput("grant_outvc",    32'(bus.grant_outvc),    32'(e.goutvc));
        checkOutput("grant_invc",     32'(bus.grant_invc),     32'(e.ginvc));
        checkOutput("grant_port_vec", 32'(bus.grant_port_vec), 32'(e.gport));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle_stim(); s.rs = 1;
    applyStimulus(s);
    applyStimulus(s);
    s = idle_stim();
    for (int i = 0; i < 10; i++) applyStimulus(s);

    // Two identical requests bind VC 2 then VC 3.
    s = idle_stim(); s.upd = 1; s.allowed = 13'h00C; s.vcn = 4'd5; s.port = 6'b000100;
    applyStimulus(s);
    applyStimulus(s);
    // Release VC 2 while requesting only VC 2: no grant this cycle, grant next cycle.
    s.allowed = 13'h004; s.rel = 1; s.rvc = 4'd2;
    applyStimulus(s);
    s.rel = 0;
    applyStimulus(s);
    s = idle_stim();
    applyStimulus(s);

    s = idle_stim(); s.rs = 1;
    applyStimulus(s);
    s = idle_stim(); s.sent = 1; s.svc = 4'd0;
    for (int i = 0; i < 5; i++) applyStimulus(s);
    s.cin = 13'h001;
    applyStimulus(s);
    s = idle_stim(); s.cin = 13'h001;
    applyStimulus(s);

    s = idle_stim(); s.rs = 1;
    applyStimulus(s);
    s = idle_stim(); s.sent = 1; s.svc = 4'd0; s.cin = 13'h001;
    applyStimulus(s);
    s = idle_stim(); s.rs = 1;
    applyStimulus(s);
    s = idle_stim(); s.cin = 13'h002;
    for (int i = 0; i < 5; i++) applyStimulus(s);

    // Fill every VC, then reset while the last grant is still being presented.
    s = idle_stim(); s.rs = 1;
    applyStimulus(s);
    s = idle_stim(); s.upd = 1; s.allowed = 13'h1FFF; s.vcn = 4'd7; s.port = 6'b100000;
    for (int i = 0; i < no_vc; i++) applyStimulus(s);
    s = idle_stim(); s.rs = 1;
    applyStimulus(s);
    s = idle_stim();
    applyStimulus(s);

    for (int i = 0; i < 2000; i++) applyStimulus(rand_stim());

    @(posedge clk);
    #2;
    checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/out_vc_tracker.md
# out_vc_tracker

Per-output-port controller that owns the output-VC busy tags and per-VC downstream credits used by the router's VC update/release arbitration. Each cycle it presents the registered `tags` vector to the update/release arbiter, accepts that arbiter's single winner, binds the lowest-index free allowed output VC to it, and reports the binding one cycle later. It frees VCs on tail departure and tracks credits per VC. One instance sits at each router output port, between the update/release arbiter and the switch/credit logic.

## Interface
- `no_inport`, 6, number of input ports
- `floorplusone_log2_no_inport`, 3, index width for input ports
- `no_vc`, 13, VCs per port
- `floorplusone_log2_no_vc`, 4, VC index width
- `buf_depth`, 4, downstream flit slots per VC (credit reset value, 1..7)
- `clk` in 1: clock, rising edge
- `rs` in 1: reset, synchronous, active-high
- `update_en` in 1: arbiter has a winner this cycle
- `vc_no` in `floorplusone_log2_no_vc`: winner's input VC number
- `allowed_vcs` in `no_vc`: winner's allowed output VCs
- `port_no_vec` in `no_inport`: winner, one-hot
- `release_en` in 1: tail flit left on `release_vc`
- `release_vc` in `floorplusone_log2_no_vc`: output VC to free
- `flit_sent_en` in 1: flit sent downstream
- `flit_sent_vc` in `floorplusone_log2_no_vc`: VC of the sent flit
- `credit_in` in `no_vc`: one credit returned per set bit
- `tags` out `no_vc`: registered busy bit per output VC (1 = allocated)
- `grant_valid` out 1: one-cycle pulse when a binding is made
- `grant_outvc` out `floorplusone_log2_no_vc`: bound output VC
- `grant_invc` out `floorplusone_log2_no_vc`: echoed `vc_no`
- `grant_port_vec` out `no_inport`: echoed `port_no_vec`
- `credit_avail` out `no_vc`: registered; bit j = credit count of VC j nonzero
- `err` out 1: sticky protocol-error flag

## Operation
- Reset (`rs`=1 at an edge): `tags`=0, all credits=`buf_depth`, `credit_avail`=all ones, `grant_valid`=0, `grant_outvc`/`grant_invc`/`grant_port_vec`=0, `err`=0. Reset overrides all inputs in the same cycle. Reset mid-allocation drops pending grants.
- Allocation: `cand = allowed_vcs & ~tags`. When `update_en` is 1 and `cand` is nonzero, j = lowest set index. At the next edge: `tags[j]`←1, `grant_valid`←1, `grant_outvc`←j, and `grant_invc`/`grant_port_vec` capture the inputs. `grant_*` data hold their values until the next grant.
- `update_en` with `cand`=0 makes no grant and sets `err`. `port_no_vec` that is not one-hot also sets `err`, but the grant still proceeds.
- Release: when `release_en` is 1, `tags[release_vc]`←0. Releasing an already-free VC sets `err`. A `release_vc` ≥ `no_vc` is ignored and sets `err`.
- Same-cycle allocation and release:
  - Allocation uses the pre-edge `tags`, so it never picks the VC being released.
  - Both updates apply at the same edge.
- Credits, per VC, counter width `floorplusone_log2_no_inport` bits:
  - Decrement on `flit_sent_en` for `flit_sent_vc`.
  - Increment on `credit_in[j]`.
  - Both in the same cycle on the same VC: counter unchanged.
  - Decrement at 0: counter stays 0, `err` set.
  - Increment at `buf_depth`: counter stays at `buf_depth`, `err` set.
- `err` clears only on `rs`.

## Timing
- `tags` and `credit_avail` are registered; there is no combinational path from any input to them.
- Allocation latency is 1 cycle from `update_en` to `grant_valid` and to the `tags` update. Back-to-back grants every cycle are supported.
- Release latency is 1 cycle; the freed VC is allocatable in the cycle after `release_en`.
- Credit latency is 1 cycle from `flit_sent_en`/`credit_in` to `credit_avail`.
- Only `cand`, the priority encoder and the error checks are combinational.

## Structure
- Shared package `router_pkg` holds the default constants (`no_inport`, `no_vc`, the log2 widths, `buf_depth`) and a `vc_idx_t`-style index width constant used by both the arbiter and this block.
- One sub-module, `vc_credit_counter`, is instantiated `no_vc` times. It contains:
  - one saturating up/down counter,
  - a nonzero flag,
  - an overflow/underflow error output.
- The lowest-index priority encoder stays inline.

## Test plan
- Reset then idle: `tags`=0, `credit_avail`=13'h1FFF, `err`=0, `grant_valid`=0 for 10 cycles.
- `update_en`=1, `allowed_vcs`=13'h00C, `vc_no`=5, `port_no_vec`=6'b000100 → next cycle: `grant_valid`=1, `grant_outvc`=2, `grant_invc`=5, `tags`=13'h004. Repeat the same request → `grant_outvc`=3, `tags`=13'h00C.
- With `tags`=13'h00C: `release_en` on VC 2 plus `update_en` with `allowed_vcs`=13'h004 in the same cycle → no grant, `err`=1, `tags`=13'h008. Following cycle, same request → `grant_outvc`=2.
- Four `flit_sent` on VC 0 → `credit_avail[0]`=0. A fifth send → `err`=1, count stays 0. `credit_in[0]` together with `flit_sent` on VC 0 → count unchanged.
- Five `credit_in[1]` from reset (count at `buf_depth`) → `err`=1, count stays 4.
- `rs` asserted while `grant_valid`=1 and `tags`=13'h1FFF → next cycle every output equals its reset value.
